// File: rtl/board_store.sv
// Chess board image store: 64 four-bit squares, start-layout sweep, move counting.
// Optional capture counting is compiled in when CAPTURE_COUNT_EN is defined.
module board_store (
    input  logic         clk,
    input  logic         reset,
    input  logic [2:0]   game_state,
    input  logic [10:0]  change_piece,
    output logic [255:0] entire_board,
    output logic         board_ready,
    output logic [7:0]   move_count,
    output logic [3:0]   white_captured,
    output logic [3:0]   black_captured,
    output logic         king_taken
);

    typedef enum logic {INIT, READY} state_t;

    state_t         state_q, state_d;
    logic [5:0]     idx_q, idx_d;
    logic [255:0]   board_q, board_d;
    logic [7:0]     move_count_q, move_count_d;

    logic           restart;
    logic           wr_en;
    logic [5:0]     wr_addr;
    logic [3:0]     wr_data;
    logic [3:0]     cur;

    function automatic logic [3:0] start_square(input logic [5:0] idx);
        logic [2:0] back;
        logic [3:0] sq;
        case (idx[5:3])
            3'd0, 3'd7: back = 3'd4;
            3'd1, 3'd6: back = 3'd2;
            3'd2, 3'd5: back = 3'd3;
            3'd3:       back = 3'd5;
            default:    back = 3'd6;
        endcase
        case (idx[2:0])
            3'd0:    sq = {1'b1, back};
            3'd1:    sq = 4'b1001;
            3'd6:    sq = 4'b0001;
            3'd7:    sq = {1'b0, back};
            default: sq = 4'b0000;
        endcase
        return sq;
    endfunction

    assign wr_addr = change_piece[5:0];
    assign wr_data = change_piece[9:6];
    assign cur     = board_q[{wr_addr, 2'b00} +: 4];
    // Restart and write are mutually exclusive by construction: restart wins.
    assign restart = (state_q == READY) && (game_state == 3'b000);
    assign wr_en   = (state_q == READY) && change_piece[10] && (game_state != 3'b000);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        board_d      = board_q;
        move_count_d = move_count_q;
        case (state_q)
            INIT: begin
                board_d[{idx_q, 2'b00} +: 4] = start_square(idx_q);
                idx_d = idx_q + 6'd1;
                if (idx_q == 6'd63) begin
                    state_d = READY;
                end
            end
            default: begin
                if (restart) begin
                    state_d      = INIT;
                    idx_d        = 6'd0;
                    move_count_d = 8'd0;
                end else if (wr_en) begin
                    board_d[{wr_addr, 2'b00} +: 4] = wr_data;
                    // A held write sees the square already emptied, so it counts once.
                    if ((wr_data[2:0] == 3'd0) && (cur[2:0] != 3'd0) &&
                        (move_count_q != 8'hFF)) begin
                        move_count_d = move_count_q + 8'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= INIT;
            idx_q        <= 6'd0;
            board_q      <= '0;
            move_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            board_q      <= board_d;
            move_count_q <= move_count_d;
        end
    end

    assign entire_board = board_q;
    assign board_ready  = (state_q == READY);
    assign move_count   = move_count_q;

`ifdef CAPTURE_COUNT_EN
    logic       capture;
    logic [3:0] white_cap_q, white_cap_d;
    logic [3:0] black_cap_q, black_cap_d;
    logic       king_taken_q, king_taken_d;

    // Landing on an opposite-colour piece; a held write sees its own colour next cycle.
    assign capture = wr_en && (wr_data[2:0] != 3'd0) && (cur[2:0] != 3'd0) &&
                     (cur[3] != wr_data[3]);

    always_comb begin
        white_cap_d  = white_cap_q;
        black_cap_d  = black_cap_q;
        king_taken_d = king_taken_q;
        if (restart) begin
            white_cap_d  = 4'd0;
            black_cap_d  = 4'd0;
            king_taken_d = 1'b0;
        end else if (capture) begin
            if (!cur[3] && (white_cap_q != 4'hF)) begin
                white_cap_d = white_cap_q + 4'd1;
            end
            if (cur[3] && (black_cap_q != 4'hF)) begin
                black_cap_d = black_cap_q + 4'd1;
            end
            if (cur[2:0] == 3'd6) begin
                king_taken_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            white_cap_q  <= 4'd0;
            black_cap_q  <= 4'd0;
            king_taken_q <= 1'b0;
        end else begin
            white_cap_q  <= white_cap_d;
            black_cap_q  <= black_cap_d;
            king_taken_q <= king_taken_d;
        end
    end

    assign white_captured = white_cap_q;
    assign black_captured = black_cap_q;
    assign king_taken     = king_taken_q;
`else
    assign white_captured = 4'd0;
    assign black_captured = 4'd0;
    assign king_taken     = 1'b0;
`endif

endmodule

// File: tb/tb_board_store.sv
// Scoreboard bench for board_store: expectations queued with stimulus, popped at check time.
module tb_board_store;

    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   game_state;
    logic [10:0]  change_piece;
    logic [255:0] entire_board;
    logic         board_ready;
    logic [7:0]   move_count;
    logic [3:0]   white_captured;
    logic [3:0]   black_captured;
    logic         king_taken;

    board_store dut (
        .clk            (clk),
        .reset          (reset),
        .game_state     (game_state),
        .change_piece   (change_piece),
        .entire_board   (entire_board),
        .board_ready    (board_ready),
        .move_count     (move_count),
        .white_captured (white_captured),
        .black_captured (black_captured),
        .king_taken     (king_taken)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [255:0] val;
    } exp_t;

    exp_t         sbq[$];
    int           total = 0;
    int           bad   = 0;
    logic [255:0] start_vec;

    function automatic logic [3:0] dut_sq(input int i);
        return entire_board[i*4 +: 4];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic build_start();
        logic [2:0] back [8];
        logic [3:0] v;
        back = '{3'd4, 3'd2, 3'd3, 3'd5, 3'd6, 3'd3, 3'd2, 3'd4};
        start_vec = '0;
        for (int c = 0; c < 8; c++) begin
            for (int r = 0; r < 8; r++) begin
                v = 4'b0000;
                if (r == 0) v = {1'b1, back[c]};
                if (r == 1) v = 4'b1001;
                if (r == 6) v = 4'b0001;
                if (r == 7) v = {1'b0, back[c]};
                start_vec[(c*8 + r)*4 +: 4] = v;
            end
        end
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b0; game_state = 3'b001; change_piece = '0;
        tick(); tick();
        sbq.push_back('{name:"rst_board", val:256'h0});
        sbq.push_back('{name:"rst_ready", val:256'h0});
        sbq.push_back('{name:"rst_counts", val:256'h0});
        e = sbq.pop_front(); total++;
        if (entire_board !== e.val) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, entire_board, e.val); end
        e = sbq.pop_front(); total++;
        if (board_ready !== e.val[0]) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, board_ready, e.val[0]); end
        e = sbq.pop_front(); total++;
        if ({move_count, white_captured, black_captured, king_taken} !== e.val[16:0]) begin
            bad++; $display("FAIL %s got=%0h want=%0h", e.name, {move_count, white_captured, black_captured, king_taken}, e.val[16:0]);
        end
        reset = 1'b1;
        repeat (63) tick();
        sbq.push_back('{name:"ready_after_63", val:256'h0});
        e = sbq.pop_front(); total++;
        if (board_ready !== e.val[0]) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, board_ready, e.val[0]); end
        tick();
        sbq.push_back('{name:"ready_after_64", val:256'h1});
        sbq.push_back('{name:"sq26", val:256'h1});
        sbq.push_back('{name:"sq27", val:256'h6});
        sbq.push_back('{name:"sq20", val:256'hE});
        sbq.push_back('{name:"sq00", val:256'hC});
        sbq.push_back('{name:"start_board", val:start_vec});
        e = sbq.pop_front(); total++;
        if (board_ready !== e.val[0]) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, board_ready, e.val[0]); end
        e = sbq.pop_front(); total++;
        if (dut_sq(8'h26) !== e.val[3:0]) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, dut_sq(8'h26), e.val[3:0]); end
        e = sbq.pop_front(); total++;
        if (dut_sq(8'h27) !== e.val[3:0]) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, dut_sq(8'h27), e.val[3:0]); end
        e = sbq.pop_front(); total++;
        if (dut_sq(8'h20) !== e.val[3:0]) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, dut_sq(8'h20), e.val[3:0]); end
        e = sbq.pop_front(); total++;
        if (dut_sq(8'h00) !== e.val[3:0]) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, dut_sq(8'h00), e.val[3:0]); end
        e = sbq.pop_front(); total++;
        if (entire_board !== e.val) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, entire_board, e.val); end
    endtask

    task automatic test_write();
        exp_t e;
        change_piece = {1'b1, 4'b0001, 6'h24};
        tick(); tick();
        change_piece = {1'b1, 4'b0000, 6'h26};
        tick();
        sbq.push_back('{name:"mc_first_clear", val:256'h1});
        e = sbq.pop_front(); total++;
        if (move_count !== e.val[7:0]) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, move_count, e.val[7:0]); end
        tick();
        change_piece = '0;
        tick();
        sbq.push_back('{name:"sq24_pawn", val:256'h1});
        sbq.push_back('{name:"sq26_empty", val:256'h0});
        sbq.push_back('{name:"mc_held_once", val:256'h1});
        e = sbq.pop_front(); total++;
        if (dut_sq(8'h24) !== e.val[3:0]) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, dut_sq(8'h24), e.val[3:0]); end
        e = sbq.pop_front(); total++;
        if (dut_sq(8'h26) !== e.val[3:0]) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, dut_sq(8'h26), e.val[3:0]); end
        e = sbq.pop_front(); total++;
        if (move_count !== e.val[7:0]) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, move_count, e.val[7:0]); end
        // Empty onto empty must not count.
        change_piece = {1'b1, 4'b0000, 6'h23};
        tick();
        change_piece = '0;
        tick();
        sbq.push_back('{name:"mc_empty_on_empty", val:256'h1});
        e = sbq.pop_front(); total++;
        if (move_count !== e.val[7:0]) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, move_count, e.val[7:0]); end
    endtask

    task automatic test_capture();
        exp_t e;
        change_piece = {1'b1, 4'b0101, 6'h21};
        tick(); tick();
        change_piece = '0;
        tick();
        sbq.push_back('{name:"sq21_queen", val:256'h5});
`ifdef CAPTURE_COUNT_EN
        sbq.push_back('{name:"cap_w_b", val:256'h01});
`else
        sbq.push_back('{name:"cap_w_b", val:256'h00});
`endif
        sbq.push_back('{name:"mc_after_cap", val:256'h1});
        e = sbq.pop_front(); total++;
        if (dut_sq(8'h21) !== e.val[3:0]) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, dut_sq(8'h21), e.val[3:0]); end
        e = sbq.pop_front(); total++;
        if ({white_captured, black_captured} !== e.val[7:0]) begin
            bad++; $display("FAIL %s got=%0h want=%0h", e.name, {white_captured, black_captured}, e.val[7:0]);
        end
        e = sbq.pop_front(); total++;
        if (move_count !== e.val[7:0]) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, move_count, e.val[7:0]); end
    endtask

    task automatic test_king();
        exp_t e;
        change_piece = {1'b1, 4'b0101, 6'h20};
        tick();
        change_piece = '0;
        tick(); tick();
`ifdef CAPTURE_COUNT_EN
        sbq.push_back('{name:"king_caps", val:{247'h0, 1'b1, 4'h0, 4'h2}});
`else
        sbq.push_back('{name:"king_caps", val:256'h0});
`endif
        sbq.push_back('{name:"sq20_queen", val:256'h5});
        e = sbq.pop_front(); total++;
        if ({king_taken, white_captured, black_captured} !== e.val[8:0]) begin
            bad++; $display("FAIL %s got=%0h want=%0h", e.name, {king_taken, white_captured, black_captured}, e.val[8:0]);
        end
        e = sbq.pop_front(); total++;
        if (dut_sq(8'h20) !== e.val[3:0]) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, dut_sq(8'h20), e.val[3:0]); end
    endtask

    task automatic test_restart();
        exp_t e;
        int   low_bad;
        game_state   = 3'b000;
        change_piece = {1'b1, 4'b0001, 6'h30};
        tick();
        game_state   = 3'b001;
        change_piece = '0;
        sbq.push_back('{name:"rs_ready_low", val:256'h0});
        sbq.push_back('{name:"rs_sq30_kept", val:256'hA});
        sbq.push_back('{name:"rs_counts_clr", val:256'h0});
        e = sbq.pop_front(); total++;
        if (board_ready !== e.val[0]) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, board_ready, e.val[0]); end
        e = sbq.pop_front(); total++;
        if (dut_sq(8'h30) !== e.val[3:0]) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, dut_sq(8'h30), e.val[3:0]); end
        e = sbq.pop_front(); total++;
        if ({move_count, white_captured, black_captured, king_taken} !== e.val[16:0]) begin
            bad++; $display("FAIL %s got=%0h want=%0h", e.name, {move_count, white_captured, black_captured, king_taken}, e.val[16:0]);
        end
        low_bad = 0;
        for (int i = 0; i < 63; i++) begin
            // A write during the sweep must be ignored.
            change_piece = (i == 10) ? {1'b1, 4'b0000, 6'h00} : 11'h0;
            tick();
            if (board_ready !== 1'b0) low_bad++;
        end
        change_piece = '0;
        sbq.push_back('{name:"rs_ready_low_63", val:256'h0});
        e = sbq.pop_front(); total++;
        if (low_bad !== e.val[31:0]) begin bad++; $display("FAIL %s got=%0d want=%0d", e.name, low_bad, e.val[31:0]); end
        tick();
        sbq.push_back('{name:"rs_ready_high", val:256'h1});
        sbq.push_back('{name:"rs_board", val:start_vec});
        sbq.push_back('{name:"rs_mc", val:256'h0});
        e = sbq.pop_front(); total++;
        if (board_ready !== e.val[0]) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, board_ready, e.val[0]); end
        e = sbq.pop_front(); total++;
        if (entire_board !== e.val) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, entire_board, e.val); end
        e = sbq.pop_front(); total++;
        if (move_count !== e.val[7:0]) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, move_count, e.val[7:0]); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        game_state = 3'b000;
        tick();
        game_state = 3'b001;
        repeat (30) tick();
        #2 reset = 1'b0;
        #1;
        sbq.push_back('{name:"mid_rst_board", val:256'h0});
        sbq.push_back('{name:"mid_rst_ready", val:256'h0});
        e = sbq.pop_front(); total++;
        if (entire_board !== e.val) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, entire_board, e.val); end
        e = sbq.pop_front(); total++;
        if (board_ready !== e.val[0]) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, board_ready, e.val[0]); end
        tick();
        reset = 1'b1;
        tick();
        sbq.push_back('{name:"mid_first_sq", val:256'hC});
        e = sbq.pop_front(); total++;
        if (entire_board !== e.val) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, entire_board, e.val); end
        repeat (62) tick();
        sbq.push_back('{name:"mid_ready_63", val:256'h0});
        e = sbq.pop_front(); total++;
        if (board_ready !== e.val[0]) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, board_ready, e.val[0]); end
        tick();
        sbq.push_back('{name:"mid_ready_64", val:256'h1});
        sbq.push_back('{name:"mid_board", val:start_vec});
        e = sbq.pop_front(); total++;
        if (board_ready !== e.val[0]) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, board_ready, e.val[0]); end
        e = sbq.pop_front(); total++;
        if (entire_board !== e.val) begin bad++; $display("FAIL %s got=%0h want=%0h", e.name, entire_board, e.val); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b0;
        game_state   = 3'b001;
        change_piece = '0;
        build_start();
        test_reset();
        test_write();
        test_capture();
        test_king();
        test_restart();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
